sort_engine: RTL

- Sequential compare-and-swap sorter. It owns the sequencing side of the less-than comparison: it decides which operand pairs are compared and acts on each result.
- Accepts a burst of up to DEPTH unsigned words on a valid/ready input stream and sorts them ascending in place, one compare-swap per cycle.
- Streams the sorted result out on a valid/ready output stream.
- Sits between a producer of unordered samples and downstream consumers that need ordered data: min/max and median taps, rank selection.

---
 rtl/sort_engine.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/sort_engine.sv
// sort_engine: loads a burst of up to DEPTH unsigned words, bubble-sorts them
// in place with one compare-swap per cycle, then streams them out ascending.
//
// Handshake rule for both streams: a word moves on a rising clk edge exactly
// when valid and ready are both high; the sender keeps data/last stable while
// valid is high and ready is low, and valid never depends combinationally on
// ready.
module sort_engine #(
    parameter int INPUT_SIZE = 4,
    parameter int DEPTH      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [INPUT_SIZE-1:0]         in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [INPUT_SIZE-1:0]         out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic [$clog2(DEPTH+1)-1:0]    count,
    output logic [1:0]                    dbg_state
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_SORT  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                 r_state;
    logic [CW-1:0]          r_count;
    logic [CW-1:0]          r_rd;
    logic [CW-1:0]          r_j;
    logic [CW-1:0]          r_p;
    logic                   r_in_ready;
    logic                   r_out_valid;
    logic                   r_out_last;
    logic                   r_busy;
    logic [INPUT_SIZE-1:0]  r_mem [DEPTH];

    logic                   w_accept;
    logic                   w_close;
    logic [CW-1:0]          w_cnt_inc;
    logic [CW-1:0]          w_n_m1;
    logic [CW-1:0]          w_n_m2;
    logic [CW-1:0]          w_j_inc;
    logic [CW-1:0]          w_rd_inc;
    logic [INPUT_SIZE-1:0]  w_lo;
    logic [INPUT_SIZE-1:0]  w_hi;
    logic                   w_swap;

    assign w_accept  = (r_state == S_LOAD) && in_valid && r_in_ready;
    assign w_cnt_inc = r_count + CW'(1);
    // The DEPTH-th word closes the burst whatever its in_last says.
    assign w_close   = in_last || (r_count == CW'(DEPTH - 1));
    assign w_n_m1    = r_count - CW'(1);
    assign w_n_m2    = r_count - CW'(2);
    assign w_j_inc   = r_j + CW'(1);
    assign w_rd_inc  = r_rd + CW'(1);

    // Compare pair for the current bubble step; strict less-than keeps equal
    // values in load order.
    assign w_lo   = r_mem[r_j[IW-1:0]];
    assign w_hi   = r_mem[w_j_inc[IW-1:0]];
    assign w_swap = (w_hi < w_lo);

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign count     = r_count;
    assign dbg_state = r_state;
    // Only entries of the live burst are ever addressed, and only in DRAIN.
    assign out_data  = r_out_valid ? r_mem[r_rd[IW-1:0]] : '0;

    // Storage: load writes during LOAD, compare-swap during SORT; no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_count[IW-1:0]] <= in_data;
        end else if ((r_state == S_SORT) && w_swap) begin
            r_mem[r_j[IW-1:0]]     <= w_hi;
            r_mem[w_j_inc[IW-1:0]] <= w_lo;
        end
    end

    // Control FSM: LOAD -> (SORT) -> DRAIN -> LOAD, with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_LOAD;
            r_count     <= '0;
            r_rd        <= '0;
            r_j         <= '0;
            r_p         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    r_in_ready <= 1'b1;
                    if (w_accept) begin
                        r_count <= w_cnt_inc;
                        if (w_close) begin
                            r_in_ready <= 1'b0;
                            r_busy     <= 1'b1;
                            r_j        <= '0;
                            r_p        <= '0;
                            r_rd       <= '0;
                            if (r_count != '0) begin
                                r_state <= S_SORT;
                            end else begin
                                // Single word: already sorted, straight to output.
                                r_state     <= S_DRAIN;
                                r_out_valid <= 1'b1;
                                r_out_last  <= 1'b1;
                            end
                        end
                    end
                end

                S_SORT: begin
                    r_in_ready <= 1'b0;
                    if (r_j == w_n_m2) begin
                        r_j <= '0;
                        if (r_p == w_n_m2) begin
                            r_state     <= S_DRAIN;
                            r_out_valid <= 1'b1;
                            // n >= 2 here, so the first word is never the last.
                            r_out_last  <= 1'b0;
                        end else begin
                            r_p <= r_p + CW'(1);
                        end
                    end else begin
                        r_j <= w_j_inc;
                    end
                end

                S_DRAIN: begin
                    r_in_ready <= 1'b0;
                    if (out_ready) begin
                        if (r_out_last) begin
                            r_state     <= S_LOAD;
                            r_count     <= '0;
                            r_rd        <= '0;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_busy      <= 1'b0;
                            r_in_ready  <= 1'b1;
                        end else begin
                            r_rd       <= w_rd_inc;
                            r_out_last <= (w_rd_inc == w_n_m1);
                        end
                    end
                end

                default: begin
                    r_state     <= S_LOAD;
                    r_count     <= '0;
                    r_rd        <= '0;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule
